// File: rtl/cache_fill_fsm_pkg.sv
// rtl/cache_fill_fsm_pkg.sv - shared state encoding and geometry defaults for the cache fill engine
package cache_fill_fsm_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  localparam int DEF_BLOCK_WORDS = 8;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 16;

  // Word-offset width inside a block; the byte-offset mask is one bit wider.
  function automatic int off_width(input int block_words);
    return $clog2(block_words);
  endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// rtl/cache_fill_fsm_fill_counter.sv - up-counter with synchronous clear and count enable
module cache_fill_fsm_fill_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss fill engine: fetches a block word by word, writes data then tag
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int OFF_W       = off_width(BLOCK_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_miss_detected,
  input  logic [ADDR_W-1:0] i_miss_address,
  output logic              o_fsm_busy,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_mem_data_valid,
  output logic              o_write_data_array,
  output logic [OFF_W-1:0]  o_fill_word_offset,
  output logic [DATA_W-1:0] o_fill_data,
  output logic              o_write_tag_array
);

  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0]  LP_BW        = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0]  LP_LAST      = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] LP_BASE_MASK = ~ADDR_W'(2 * BLOCK_WORDS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  w_req_cnt;
  logic [CNT_W-1:0]  w_rcv_cnt;
  logic              w_fill;
  logic              w_accept;
  logic              w_mem_req;
  logic              w_wr;
  logic              w_last;
  logic [ADDR_W-1:0] w_req_byte_off;

  assign w_fill    = (r_state == ST_FILL);
  assign w_accept  = !w_fill && i_miss_detected;
  assign w_mem_req = w_fill && (w_req_cnt < LP_BW);
  assign w_wr      = w_fill && i_mem_data_valid && (w_rcv_cnt < LP_BW);
  assign w_last    = w_wr && (w_rcv_cnt == LP_LAST);

  // Base is block aligned, so adding the word offset never carries out of the block.
  assign w_req_byte_off = ADDR_W'({w_req_cnt[OFF_W-1:0], 1'b0});

  cache_fill_fsm_fill_counter #(.W(CNT_W)) u_req_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_accept),
    .i_en    (w_mem_req),
    .o_count (w_req_cnt)
  );

  cache_fill_fsm_fill_counter #(.W(CNT_W)) u_rcv_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_accept),
    .i_en    (w_wr),
    .o_count (w_rcv_cnt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_base  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_miss_detected) begin
            r_base  <= i_miss_address & LP_BASE_MASK;
            r_state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_fsm_busy         = w_fill || w_accept;
  assign o_mem_req          = w_mem_req;
  assign o_mem_addr         = w_mem_req ? (r_base + w_req_byte_off) : '0;
  assign o_write_data_array = w_wr;
  assign o_fill_word_offset = w_wr ? w_rcv_cnt[OFF_W-1:0] : '0;
  assign o_fill_data        = w_wr ? i_mem_data : '0;
  assign o_write_tag_array  = w_last;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - scoreboard bench for cache_fill_fsm against a 4-cycle in-order memory
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_miss_detected;
  logic [15:0] i_miss_address;
  logic        o_fsm_busy;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic [15:0] i_mem_data;
  logic        i_mem_data_valid;
  logic        o_write_data_array;
  logic [2:0]  o_fill_word_offset;
  logic [15:0] o_fill_data;
  logic        o_write_tag_array;

  typedef struct { int cyc; logic [15:0] addr; } req_t;
  typedef struct { int cyc; logic [2:0] off; logic [15:0] data; logic tag; } wr_t;
  typedef struct { int cyc; int kind; } pt_t;
  typedef struct { int due; logic [15:0] data; } mem_t;

  req_t exp_req[$];
  wr_t  exp_wr[$];
  pt_t  exp_pt[$];
  mem_t mem_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit gap_mode = 1'b0;
  bit inj      = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_fill_fsm dut (
    .i_clk              (clk),
    .i_rst              (i_rst),
    .i_miss_detected    (i_miss_detected),
    .i_miss_address     (i_miss_address),
    .o_fsm_busy         (o_fsm_busy),
    .o_mem_req          (o_mem_req),
    .o_mem_addr         (o_mem_addr),
    .i_mem_data         (i_mem_data),
    .i_mem_data_valid   (i_mem_data_valid),
    .o_write_data_array (o_write_data_array),
    .o_fill_word_offset (o_fill_word_offset),
    .o_fill_data        (o_fill_data),
    .o_write_tag_array  (o_write_tag_array)
  );

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a ^ 16'hC3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fill(input logic [15:0] base, input int req_t0, input int wr_t0);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      a = base + 16'(2 * i);
      exp_req.push_back('{(req_t0 < 0) ? -1 : req_t0 + i, a});
      exp_wr.push_back('{(wr_t0 < 0) ? -1 : wr_t0 + i, 3'(i), mem_fn(a), (i == 7)});
    end
  endtask

  task automatic busy_window(input int t0, input int t1);
    for (int c = t0; c <= t1; c++) exp_pt.push_back('{c, 1});
    exp_pt.push_back('{t1 + 1, 0});
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (exp_req.size() == 0 && exp_wr.size() == 0 && exp_pt.size() == 0 && !o_fsm_busy) break;
      next_cycle();
    end
    check({name, "_drained"}, exp_req.size() + exp_wr.size() + exp_pt.size() + 32'(o_fsm_busy), 0);
  endtask

  // Scoreboard monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    req_t r;
    wr_t  w;
    pt_t  p;
    forever begin
      @(negedge clk);
      if (o_mem_req) begin
        if (exp_req.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_req at cycle %0d: got addr 0x%0h expected no request", cyc, o_mem_addr);
        end else begin
          r = exp_req.pop_front();
          check("req_addr", o_mem_addr, r.addr);
          if (r.cyc >= 0) check("req_cycle", cyc, r.cyc);
        end
      end
      if (o_write_data_array) begin
        if (exp_wr.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write at cycle %0d: got offset %0d expected no write", cyc, o_fill_word_offset);
        end else begin
          w = exp_wr.pop_front();
          check("wr_offset", o_fill_word_offset, w.off);
          check("wr_data", o_fill_data, w.data);
          check("wr_tag", o_write_tag_array, w.tag);
          if (w.cyc >= 0) check("wr_cycle", cyc, w.cyc);
        end
      end else begin
        check("nowrite_zero", {o_write_tag_array, o_fill_word_offset, o_fill_data}, 0);
      end
      while (exp_pt.size() > 0 && exp_pt[0].cyc <= cyc) begin
        p = exp_pt.pop_front();
        if (p.cyc < cyc) begin
          n_checks++; n_fail++;
          $display("FAIL missed_point at cycle %0d: got late check expected cycle %0d", cyc, p.cyc);
        end else if (p.kind == 2) begin
          check("all_zero", {o_fsm_busy, o_mem_req, o_mem_addr, o_write_data_array,
                             o_fill_word_offset, o_fill_data, o_write_tag_array}, 0);
        end else begin
          check("busy", o_fsm_busy, p.kind);
        end
      end
    end
  end

  // Memory request capture; a reset also clears outstanding memory reads.
  initial begin
    forever begin
      @(negedge clk);
      if (i_rst) mem_q.delete();
      else if (o_mem_req) mem_q.push_back('{cyc + 4, mem_fn(o_mem_addr)});
    end
  end

  initial begin
    mem_t m;
    i_mem_data_valid = 1'b0;
    i_mem_data       = 16'h0;
    forever begin
      @(posedge clk);
      #2;
      if (inj) begin
        i_mem_data_valid = 1'b1;
        i_mem_data       = 16'hBEEF;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc && (!gap_mode || (cyc % 2 == 0))) begin
        m = mem_q.pop_front();
        i_mem_data_valid = 1'b1;
        i_mem_data       = m.data;
      end else begin
        i_mem_data_valid = 1'b0;
        i_mem_data       = 16'h0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    i_rst           = 1'b1;
    i_miss_detected = 1'b0;
    i_miss_address  = 16'h0;
    next_cycle();
    next_cycle();
    i_rst = 1'b0;
    exp_pt.push_back('{cyc, 2});
    next_cycle();
    wait_drain("reset", 5);

    // Single miss with 4-cycle memory
    t = cyc;
    i_miss_detected = 1'b1;
    i_miss_address  = 16'h1236;
    expect_fill(16'h1230, t + 1, t + 5);
    busy_window(t, t + 12);
    next_cycle();
    i_miss_detected = 1'b0;
    wait_drain("basic", 40);

    // Memory returning valid only on alternate cycles
    gap_mode = 1'b1;
    i_miss_detected = 1'b1;
    i_miss_address  = 16'h0480;
    expect_fill(16'h0480, cyc + 1, -1);
    next_cycle();
    i_miss_detected = 1'b0;
    wait_drain("gaps", 60);
    gap_mode = 1'b0;

    // Miss held high for 20 cycles; address changes mid-fill
    t = cyc;
    i_miss_detected = 1'b1;
    i_miss_address  = 16'h0040;
    expect_fill(16'h0040, t + 1, t + 5);
    expect_fill(16'h0050, t + 14, t + 18);
    busy_window(t, t + 25);
    repeat (3) next_cycle();
    i_miss_address = 16'h0050;
    repeat (17) next_cycle();
    i_miss_detected = 1'b0;
    wait_drain("held", 40);

    // Reset in the middle of a fill, then restart
    t = cyc;
    i_miss_detected = 1'b1;
    i_miss_address  = 16'h3006;
    for (int i = 0; i < 7; i++) exp_req.push_back('{t + 1 + i, 16'h3000 + 16'(2 * i)});
    for (int i = 0; i < 3; i++) exp_wr.push_back('{t + 5 + i, 3'(i), mem_fn(16'h3000 + 16'(2 * i)), 1'b0});
    next_cycle();
    i_miss_detected = 1'b0;
    repeat (6) next_cycle();
    i_rst = 1'b1;
    next_cycle();
    i_rst = 1'b0;
    exp_pt.push_back('{cyc, 2});
    next_cycle();
    next_cycle();
    t = cyc;
    i_miss_detected = 1'b1;
    i_miss_address  = 16'h2000;
    expect_fill(16'h2000, t + 1, t + 5);
    busy_window(t, t + 12);
    next_cycle();
    i_miss_detected = 1'b0;
    wait_drain("reset_mid", 40);

    // Stray memory data while idle
    inj = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_pt.push_back('{cyc, 2});
      next_cycle();
    end
    inj = 1'b0;
    wait_drain("idle_data", 5);

    // Top-of-address-space block
    t = cyc;
    i_miss_detected = 1'b1;
    i_miss_address  = 16'hFFFE;
    expect_fill(16'hFFF0, t + 1, t + 5);
    busy_window(t, t + 12);
    next_cycle();
    i_miss_detected = 1'b0;
    wait_drain("top", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
